// File: rtl/regfile_stream_ctrl_if.sv
// Stream bundle for regfile_stream_ctrl: command, load-in and dump-out channels.
// master = host/DMA side, slave = controller side.
interface regfile_stream_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 32
);
  localparam int unsigned ADDR_WIDTH = (N > 1) ? $clog2(N) : 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [ADDR_WIDTH-1:0] cmd_cnt;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_cnt,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_cnt,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );
endinterface

// File: rtl/regfile_stream_ctrl.sv
// Block-command controller driving a regfile: LOAD streams words into consecutive
// entries, DUMP streams consecutive entries out with a last flag.
// Optional running XOR checksum: define REGFILE_STREAM_CTRL_CKSUM_EN.
module regfile_stream_ctrl #(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned N          = 32,
  localparam int unsigned ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_stream_ctrl_if.slave  bus,
  output logic [ADDR_WIDTH-1:0] rf_R_addr,
  output logic                  rf_R_en,
  input  logic [WIDTH-1:0]      rf_R_data,
  output logic [ADDR_WIDTH-1:0] rf_W_addr,
  output logic                  rf_W_en,
  output logic [WIDTH-1:0]      rf_W_data,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      cksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  state_e                r_state;
  state_e                w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_issued_all;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [WIDTH-1:0]      r_out_data;

  logic                  w_cmd_ready;
  logic                  w_in_ready;
  logic                  w_rd_issue;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_load_hs;
  logic                  w_out_hs;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_accept   = w_cmd_ready & bus.cmd_valid;
  assign w_load_hs  = w_in_ready & bus.in_valid;
  assign w_out_hs   = r_out_valid & bus.out_ready;
  assign w_addr_inc = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.cmd_valid) w_next_state = bus.cmd_op ? S_DUMP : S_LOAD;
      S_LOAD: if (bus.in_valid && (r_remaining == '0)) w_next_state = S_DONE;
      S_DUMP: if (w_out_hs && r_out_last) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded controls; a read issues when the output slot is free or draining
  always_comb begin
    w_cmd_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_rd_issue  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
      end
      S_LOAD: w_in_ready = 1'b1;
      S_DUMP: w_rd_issue = !r_issued_all && (!r_out_valid || bus.out_ready);
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Address sequencing, remaining count and one-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_issued_all <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else if (w_accept) begin
      r_addr       <= bus.cmd_base;
      r_remaining  <= bus.cmd_cnt;
      r_issued_all <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else if (w_load_hs) begin
      r_addr <= w_addr_inc;
      if (r_remaining != '0) r_remaining <= r_remaining - ADDR_WIDTH'(1);
    end else if (w_rd_issue) begin
      r_addr      <= w_addr_inc;
      r_out_data  <= rf_R_data;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_remaining == '0);
      if (r_remaining == '0) r_issued_all <= 1'b1;
      else                   r_remaining  <= r_remaining - ADDR_WIDTH'(1);
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = w_busy;
  assign done          = w_done;

  // Regfile port drive: pass-through writes, combinational reads, zero when idle
  assign rf_W_en   = w_load_hs;
  assign rf_W_addr = w_load_hs ? r_addr : '0;
  assign rf_W_data = w_load_hs ? bus.in_data : '0;
  assign rf_R_en   = w_rd_issue;
  assign rf_R_addr = w_rd_issue ? r_addr : '0;

`ifdef REGFILE_STREAM_CTRL_CKSUM_EN
  logic [WIDTH-1:0] r_cksum;

  // XOR of every word moved by the current command; held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cksum <= '0;
    end else if (w_accept) begin
      r_cksum <= '0;
    end else if (w_load_hs) begin
      r_cksum <= r_cksum ^ bus.in_data;
    end else if (w_out_hs) begin
      r_cksum <= r_cksum ^ r_out_data;
    end
  end

  assign cksum = r_cksum;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_regfile_stream_ctrl.sv
// Randomized bench for regfile_stream_ctrl with a regfile model and an
// array-based reference of expected regfile contents.
module tb_regfile_stream_ctrl;
  localparam int unsigned W     = 32;
  localparam int unsigned N     = 32;
  localparam int unsigned AW    = 5;
  localparam int          LIMIT = 400;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rf_R_addr;
  logic          rf_R_en;
  logic [W-1:0]  rf_R_data;
  logic [AW-1:0] rf_W_addr;
  logic          rf_W_en;
  logic [W-1:0]  rf_W_data;
  logic          busy;
  logic          done;
  logic [W-1:0]  cksum;

  logic [W-1:0]  mem     [N];
  logic [W-1:0]  ref_mem [N];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_stream_ctrl_if #(.WIDTH(W), .N(N)) bus ();

  regfile_stream_ctrl #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rf_R_addr (rf_R_addr),
    .rf_R_en   (rf_R_en),
    .rf_R_data (rf_R_data),
    .rf_W_addr (rf_W_addr),
    .rf_W_en   (rf_W_en),
    .rf_W_data (rf_W_data),
    .busy      (busy),
    .done      (done),
    .cksum     (cksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: synchronous write, combinational read
  always @(posedge clk) if (rf_W_en) mem[rf_W_addr] <= rf_W_data;
  assign rf_R_data = mem[rf_R_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_ck(input logic [W-1:0] v);
`ifdef REGFILE_STREAM_CTRL_CKSUM_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic issue_cmd(input bit op, input int base, input int cnt);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = AW'(base);
    bus.cmd_cnt   = AW'(cnt);
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_we", rf_W_en, 0);
    check("idle_re", rf_R_en, 0);
    @(posedge clk);
  endtask

  task automatic check_done(input logic [W-1:0] ck);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_cmd_ready", bus.cmd_ready, 0);
    check("done_out_valid", bus.out_valid, 0);
    check("done_we", rf_W_en, 0);
    check("cksum_at_done", cksum, exp_ck(ck));
    @(negedge clk);
    #1;
    check("done_clear", done, 0);
    check("after_cmd_ready", bus.cmd_ready, 1);
    check("after_busy", busy, 0);
    check("cksum_hold", cksum, exp_ck(ck));
  endtask

  task automatic do_load(input int base, input int cnt, input logic [W-1:0] words[$], input bit gaps);
    int k = 0;
    int cyc = 0;
    bit v;
    logic [W-1:0] ck = '0;
    issue_cmd(1'b0, base, cnt);
    while (k <= cnt && cyc < LIMIT) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = words[k];
      #1;
      check("load_in_ready", bus.in_ready, 1);
      check("load_cmd_ready", bus.cmd_ready, 0);
      check("load_we", rf_W_en, v);
      if (v) begin
        check("load_waddr", rf_W_addr, (base + k) % N);
        check("load_wdata", rf_W_data, words[k]);
        ref_mem[(base + k) % N] = words[k];
        ck ^= words[k];
        k++;
      end else begin
        check("load_waddr_idle", rf_W_addr, 0);
      end
      cyc++;
    end
    check("load_timeout", cyc < LIMIT, 1);
    check_done(ck);
  endtask

  task automatic do_dump(input int base, input int cnt, input bit rnd, input bit pat[$]);
    int k = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit r;
    logic [W-1:0] pdata = '0;
    logic [W-1:0] ck = '0;
    issue_cmd(1'b1, base, cnt);
    while (k <= cnt && cyc < LIMIT) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (pat.size() > 0) r = pat.pop_front();
      else                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = r;
      #1;
      check("dump_busy", busy, 1);
      check("dump_in_ready", bus.in_ready, 0);
      if (!rf_R_en) check("dump_raddr_idle", rf_R_addr, 0);
      if (pend) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, pdata);
      end
      if (bus.out_valid) begin
        if (r) begin
          check("dump_data", bus.out_data, ref_mem[(base + k) % N]);
          check("dump_last", bus.out_last, (k == cnt));
          ck ^= bus.out_data;
          k++;
          pend = 1'b0;
        end else begin
          pend  = 1'b1;
          pdata = bus.out_data;
        end
      end
      cyc++;
    end
    check("dump_timeout", cyc < LIMIT, 1);
    check("dump_hs_count", k, cnt + 1);
    check_done(ck);
  endtask

  initial begin
    logic [W-1:0] q[$];
    bit           p[$];
    int           b;
    int           c;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_cnt   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_cksum", cksum, 0);
    check("rst_we", rf_W_en, 0);
    check("rst_re", rf_R_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every entry once, then dump all entries starting mid-array
    q = {};
    for (int i = 0; i < N; i++) q.push_back($urandom);
    do_load(0, N - 1, q, 1'b1);
    p = {};
    do_dump(5, N - 1, 1'b1, p);

    // Directed LOAD/DUMP of 0xA0..0xA3 at base 3
    q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_load(3, 3, q, 1'b0);
    do_dump(3, 3, 1'b0, p);

    // Wrap across N-1 -> 0
    q = {};
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    do_load(30, 3, q, 1'b0);
    do_dump(30, 3, 1'b0, p);

    // Backpressure pattern 1,0,0,1,1
    p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_dump(7, 2, 1'b0, p);
    p = {};

    // Single-word commands
    q = '{32'h1234_5678};
    do_load(31, 0, q, 1'b0);
    do_dump(31, 0, 1'b0, p);

    // Checksum cancels to zero
    q = '{32'h0F, 32'hF0, 32'hFF};
    do_load(20, 2, q, 1'b0);

    // Reset mid-LOAD after 2 of 4 words
    issue_cmd(1'b0, 10, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hC0DE_0000 + 32'(i);
      #1;
      check("rload_we", rf_W_en, 1);
      ref_mem[10 + i] = bus.in_data;
    end
    @(negedge clk);
    bus.in_data = 32'hC0DE_0002;
    rst_n       = 1'b0;
    #1;
    check("rload_we_drop", rf_W_en, 0);
    check("rload_in_ready", bus.in_ready, 0);
    check("rload_busy", busy, 0);
    check("rload_cmd_ready", bus.cmd_ready, 1);
    check("rload_cksum", cksum, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    do_dump(10, 3, 1'b0, p);

    // Random mix of commands
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, N - 1);
      c = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 0) begin
        q = {};
        for (int i = 0; i <= c; i++) q.push_back($urandom);
        do_load(b, c, q, 1'b1);
      end else begin
        do_dump(b, c, 1'b1, p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
